// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE/RUN/CRASH/OVER sequencing, gated tick/drop pulses, BCD score, lives, crash flash.
// Pulses and flash are registered (1-cycle latency); running/game_over follow state directly; no backpressure.
module game_sequencer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SLOW_DIV     = 131072,
  parameter int FAST_DIV     = 65536,
  parameter int DROP_DIV     = 13290485,
  parameter int FLASH_DIV    = 131072,
  parameter int CRASH_SECS   = 2,
  parameter int LIVES        = 3,
  parameter int SCORE_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      colision,
  output logic                      tick_slow,
  output logic                      tick_fast,
  output logic                      drop,
  output logic                      running,
  output logic                      game_over,
  output logic                      flash,
  output logic [3:0]                lives,
  output logic [4*SCORE_DIGITS-1:0] score
);

  localparam int CRASH_CYC = CRASH_SECS * CLK_HZ;
  localparam int SLOW_W  = (SLOW_DIV  > 1) ? $clog2(SLOW_DIV)  : 1;
  localparam int FAST_W  = (FAST_DIV  > 1) ? $clog2(FAST_DIV)  : 1;
  localparam int DROP_W  = (DROP_DIV  > 1) ? $clog2(DROP_DIV)  : 1;
  localparam int SEC_W   = (CLK_HZ    > 1) ? $clog2(CLK_HZ)    : 1;
  localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int CRASH_W = (CRASH_CYC > 1) ? $clog2(CRASH_CYC) : 1;

  localparam logic [SLOW_W-1:0]  SLOW_TC  = SLOW_W'(SLOW_DIV - 1);
  localparam logic [FAST_W-1:0]  FAST_TC  = FAST_W'(FAST_DIV - 1);
  localparam logic [DROP_W-1:0]  DROP_TC  = DROP_W'(DROP_DIV - 1);
  localparam logic [SEC_W-1:0]   SEC_TC   = SEC_W'(CLK_HZ - 1);
  localparam logic [FLASH_W-1:0] FLASH_TC = FLASH_W'(FLASH_DIV - 1);
  localparam logic [CRASH_W-1:0] CRASH_TC = CRASH_W'(CRASH_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, CRASH, OVER} state_t;

  state_t               state, state_nxt;
  logic [SLOW_W-1:0]    slow_cnt;
  logic [FAST_W-1:0]    fast_cnt;
  logic [DROP_W-1:0]    drop_cnt;
  logic [SEC_W-1:0]     sec_cnt;
  logic [FLASH_W-1:0]   flash_cnt;
  logic [CRASH_W-1:0]   crash_cnt;
  logic                 tick_slow_q, tick_fast_q, drop_q, flash_q;
  logic                 active, clear_game, crash_hit, over_hit;
  logic                 crash_done;

  function automatic logic [4*SCORE_DIGITS-1:0] bcd_inc(input logic [4*SCORE_DIGITS-1:0] s);
    logic carry;
    bcd_inc = s;
    carry   = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (s[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = s[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    // Carry out of the top digit means all nines: hold instead of wrapping.
    if (carry) bcd_inc = s;
  endfunction

  assign crash_done = (crash_cnt == CRASH_TC);

  always_comb begin
    state_nxt  = state;
    active     = (state == RUN) && !pause;
    clear_game = 1'b0;
    crash_hit  = 1'b0;
    over_hit   = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_nxt  = RUN;
          clear_game = 1'b1;
        end
      end
      RUN: begin
        if (active && colision) begin
          if (lives > 4'd1) begin
            state_nxt = CRASH;
            crash_hit = 1'b1;
          end else begin
            state_nxt = OVER;
            over_hit  = 1'b1;
          end
        end
      end
      CRASH: begin
        if (crash_done && !colision) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      slow_cnt    <= '0;
      fast_cnt    <= '0;
      drop_cnt    <= '0;
      sec_cnt     <= '0;
      flash_cnt   <= '0;
      crash_cnt   <= '0;
      score       <= '0;
      lives       <= 4'(LIVES);
      tick_slow_q <= 1'b0;
      tick_fast_q <= 1'b0;
      drop_q      <= 1'b0;
      flash_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      // The colliding cycle still advances counters but its pulses would land in CRASH/OVER.
      tick_slow_q <= active && !colision && (slow_cnt == SLOW_TC);
      tick_fast_q <= active && !colision && (fast_cnt == FAST_TC);
      drop_q      <= active && !colision && (drop_cnt == DROP_TC);

      if (clear_game) begin
        slow_cnt <= '0;
        fast_cnt <= '0;
        drop_cnt <= '0;
        sec_cnt  <= '0;
        score    <= '0;
        lives    <= 4'(LIVES);
      end else if (active) begin
        slow_cnt <= (slow_cnt == SLOW_TC) ? '0 : slow_cnt + SLOW_W'(1);
        fast_cnt <= (fast_cnt == FAST_TC) ? '0 : fast_cnt + FAST_W'(1);
        drop_cnt <= (drop_cnt == DROP_TC) ? '0 : drop_cnt + DROP_W'(1);
        sec_cnt  <= (sec_cnt == SEC_TC) ? '0 : sec_cnt + SEC_W'(1);
        if (sec_cnt == SEC_TC) score <= bcd_inc(score);
        if (crash_hit) lives <= lives - 4'd1;
        if (over_hit)  lives <= 4'd0;
      end else if (state == CRASH) begin
        sec_cnt <= (sec_cnt == SEC_TC) ? '0 : sec_cnt + SEC_W'(1);
      end

      if (crash_hit) begin
        crash_cnt <= '0;
        flash_cnt <= '0;
        flash_q   <= 1'b1;
      end else if (state == CRASH) begin
        if (state_nxt != CRASH) begin
          flash_q <= 1'b0;
        end else begin
          if (!crash_done) crash_cnt <= crash_cnt + CRASH_W'(1);
          flash_cnt <= (flash_cnt == FLASH_TC) ? '0 : flash_cnt + FLASH_W'(1);
          if (flash_cnt == FLASH_TC) flash_q <= !flash_q;
        end
      end else begin
        flash_q <= 1'b0;
      end
    end
  end

  assign tick_slow = tick_slow_q && !reset;
  assign tick_fast = tick_fast_q && !reset;
  assign drop      = drop_q && !reset;
  assign flash     = flash_q && !reset;
  assign running   = (state == RUN) && !pause && !reset;
  assign game_over = (state == OVER) && !reset;

endmodule
